// File: rtl/fetch_sequencer_if.sv
// Fetch-stage control bundle: decode/redirect inputs, imem handshake and status outputs.
// master drives the decode/redirect/ack side, slave is the sequencer.
interface fetch_sequencer_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             stallD;
    logic             Branch;
    logic             pcSrcW;
    logic             imemAck;
    logic             imemReq;
    logic             pcEnable;
    logic             pipeEnable;
    logic             flushD;
    logic             imemErr;
    logic [CNT_W-1:0] stallCount;

    modport master (
        output stallD, Branch, pcSrcW, imemAck,
        input  imemReq, pcEnable, pipeEnable, flushD, imemErr, stallCount
    );

    modport slave (
        input  stallD, Branch, pcSrcW, imemAck,
        output imemReq, pcEnable, pipeEnable, flushD, imemErr, stallCount
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: single-outstanding imem handshake, decode stall hold, redirect flush,
// discard of in-flight fetches after a redirect, memory timeout and a stall-cycle counter.
module fetch_sequencer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input logic              clock,
    input logic              rst,
    fetch_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StHold,
        StDrain,
        StHalt
    } state_e;

    localparam logic [16:0] TimeoutVal = 17'(TIMEOUT);

    state_e           state_q, state_d;
    logic [15:0]      timer_q, timer_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic redirect;
    logic ack;
    logic stall;
    logic timer_hit;
    logic req;
    logic pc_en;
    logic pipe_en;
    logic flush;

    assign redirect  = bus.Branch | bus.pcSrcW;
    assign ack       = bus.imemAck;
    assign stall     = bus.stallD;
    assign timer_hit = ({1'b0, timer_q} + 17'd1) == TimeoutVal;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: state_d = StIssue;
            StIssue: begin
                if (!redirect) begin
                    state_d = StWait;
                    timer_d = '0;
                end
            end
            StWait: begin
                if (redirect) begin
                    if (ack) begin
                        state_d = StIssue;
                    end else begin
                        state_d = StDrain;
                        timer_d = '0;
                    end
                end else if (ack) begin
                    state_d = stall ? StHold : StIssue;
                end else if (timer_hit) begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StHold: begin
                if (redirect || !stall) begin
                    state_d = StIssue;
                end
            end
            StDrain: begin
                // A redirect here re-steers the PC but the old fetch is still in flight.
                if (ack) begin
                    state_d = StIssue;
                end else if (timer_hit) begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req     = 1'b0;
        pc_en   = 1'b0;
        pipe_en = 1'b0;
        flush   = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIssue: begin
                    if (redirect) begin
                        pc_en = 1'b1;
                        flush = 1'b1;
                    end else begin
                        req = 1'b1;
                    end
                end
                StWait: begin
                    if (redirect) begin
                        pc_en = 1'b1;
                        flush = 1'b1;
                    end else if (ack && !stall) begin
                        pc_en   = 1'b1;
                        pipe_en = 1'b1;
                    end
                end
                StHold: begin
                    if (redirect) begin
                        pc_en = 1'b1;
                        flush = 1'b1;
                    end else if (!stall) begin
                        pc_en   = 1'b1;
                        pipe_en = 1'b1;
                    end
                end
                StDrain: begin
                    if (redirect) begin
                        pc_en = 1'b1;
                        flush = 1'b1;
                    end
                end
                default: begin
                    req = 1'b0;
                end
            endcase
        end
    end

    // Any active cycle that does not advance the PC is a stall, ISSUE included.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == StIssue || state_q == StWait || state_q == StHold ||
             state_q == StDrain) && !pc_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign bus.imemReq    = req;
    assign bus.pcEnable   = pc_en;
    assign bus.pipeEnable = pipe_en;
    assign bus.flushD     = flush;
    assign bus.imemErr    = err_q;
    assign bus.stallCount = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer against a flag-based fetch model.
module tb_fetch_sequencer;
    localparam int unsigned TO = 8;
    localparam int unsigned CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clock;
    logic rst;
    int   checks;
    int   errors;

    fetch_sequencer_if #(.CNT_W(CW)) bus ();

    fetch_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock(clock),
        .rst  (rst),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory model
    int   mem_lat;
    int   lat_cnt;
    logic pend;
    logic mem_ack;
    logic req_prev;

    // Reference model
    logic check_en;
    logic m_fresh, m_halt, m_out, m_drop, m_held, m_err;
    int   m_wait, m_cnt;
    logic e_req, e_pc, e_pipe, e_fl, rd;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic b, input logic p,
                         input logic fa);
        @(posedge clock);
        #1;
        rst        = r;
        bus.stallD = s;
        bus.Branch = b;
        bus.pcSrcW = p;
        if (r) begin
            mem_ack = 1'b0;
            pend    = 1'b0;
            lat_cnt = 0;
        end else if (req_prev) begin
            mem_ack = (mem_lat <= 1);
            pend    = (mem_lat > 1);
            lat_cnt = mem_lat - 1;
        end else if (pend) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                mem_ack = 1'b1;
                pend    = 1'b0;
            end
        end
        bus.imemAck = mem_ack | fa;
        @(negedge clock);
        req_prev = bus.imemReq;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        m_wait++;
        if (m_wait == int'(TO)) begin
            m_halt = 1'b1;
            m_err  = 1'b1;
        end
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            e_req  = 1'b0;
            e_pc   = 1'b0;
            e_pipe = 1'b0;
            e_fl   = 1'b0;
            rd     = bus.Branch | bus.pcSrcW;
            chk("imemErr", int'(bus.imemErr), int'(m_err));
            chk("stallCount", int'(bus.stallCount), m_cnt);
            if (rst) begin
                m_fresh = 1'b1;
                m_halt  = 1'b0;
                m_out   = 1'b0;
                m_drop  = 1'b0;
                m_held  = 1'b0;
                m_err   = 1'b0;
                m_wait  = 0;
                m_cnt   = 0;
            end else if (m_fresh) begin
                m_fresh = 1'b0;
            end else if (!m_halt) begin
                if (m_held) begin
                    if (rd) begin
                        e_pc = 1'b1; e_fl = 1'b1; m_held = 1'b0;
                    end else if (!bus.stallD) begin
                        e_pc = 1'b1; e_pipe = 1'b1; m_held = 1'b0;
                    end
                end else if (!m_out) begin
                    if (rd) begin
                        e_pc = 1'b1; e_fl = 1'b1;
                    end else begin
                        e_req = 1'b1; m_out = 1'b1; m_drop = 1'b0; m_wait = 0;
                    end
                end else if (rd) begin
                    e_pc = 1'b1; e_fl = 1'b1;
                    if (bus.imemAck) m_out = 1'b0;
                    else if (!m_drop) begin
                        m_drop = 1'b1; m_wait = 0;
                    end else tick();
                end else if (bus.imemAck) begin
                    m_out = 1'b0;
                    if (!m_drop) begin
                        if (bus.stallD) m_held = 1'b1;
                        else begin
                            e_pc = 1'b1; e_pipe = 1'b1;
                        end
                    end
                end else begin
                    tick();
                end
                if (!e_pc && m_cnt < CMAX) m_cnt++;
            end
            chk("imemReq", int'(bus.imemReq), int'(e_req));
            chk("pcEnable", int'(bus.pcEnable), int'(e_pc));
            chk("pipeEnable", int'(bus.pipeEnable), int'(e_pipe));
            chk("flushD", int'(bus.flushD), int'(e_fl));
        end
    end

    initial begin
        checks = 0; errors = 0; check_en = 1'b0;
        rst = 1'b1; bus.stallD = 1'b0; bus.Branch = 1'b0; bus.pcSrcW = 1'b0;
        bus.imemAck = 1'b0;
        mem_lat = 1; lat_cnt = 0; pend = 1'b0; mem_ack = 1'b0; req_prev = 1'b0;
        m_fresh = 1'b1; m_halt = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_held = 1'b0;
        m_err = 1'b0; m_wait = 0; m_cnt = 0;
        do_reset();
        check_en = 1'b1;

        // Back-to-back fetches, 1-cycle ack latency
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("t1_req", int'(bus.imemReq), (i % 2 == 1) ? 1 : 0);
            chk("t1_pc", int'(bus.pcEnable), (i > 0 && i % 2 == 0) ? 1 : 0);
        end

        // Ack under a 3-cycle decode stall
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("t2_pc_low", int'(bus.pcEnable), 0);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_pipe_high", int'(bus.pipeEnable), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_count", int'(bus.stallCount), 4);

        // Branch in WAIT, ack four cycles later is discarded
        do_reset();
        mem_lat = 5;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_flush", int'(bus.flushD), 1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_ack_dropped", int'(bus.pipeEnable), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_reissue", int'(bus.imemReq), 1);

        // Branch with same-cycle ack, then branch in ISSUE
        do_reset();
        mem_lat = 1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_pipe", int'(bus.pipeEnable), 0);
        chk("t4_pc", int'(bus.pcEnable), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_req_suppressed", int'(bus.imemReq), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_req", int'(bus.imemReq), 1);

        // Timeout: no ack ever
        do_reset();
        mem_lat = 100000;
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_err_before", int'(bus.imemErr), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_err_rise", int'(bus.imemErr), 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            chk("t5_halt_pc", int'(bus.pcEnable), 0);
        end

        // Reset mid-WAIT and mid-DRAIN
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_wait_cnt", int'(bus.stallCount), 0);
        chk("t6_wait_req", int'(bus.imemReq), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_drain_cnt", int'(bus.stallCount), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_drain_req", int'(bus.imemReq), 1);

        // Long stall saturates the counter
        do_reset();
        mem_lat = 1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 21; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t7_saturate", int'(bus.stallCount), CMAX);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic r, s, b, p;
            r = ($urandom_range(99) == 0) || (m_halt && $urandom_range(9) == 0);
            s = ($urandom_range(9) < 3);
            b = ($urandom_range(9) == 0);
            p = ($urandom_range(19) == 0);
            mem_lat = ($urandom_range(39) == 0) ? 12 : int'($urandom_range(4, 1));
            cycle(r, s, b, p, 1'b0);
        end

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
